float_copro_ctrl: RTL and testbench
===================================

// Module: float_copro_ctrl
// PURPOSE
//  Sequencer between the LM32 user-defined-instruction (UDI) port and the float coprocessor datapath
//  (float_copro_dp, purely combinational). Accepts one UDI request and registers opcode/operands.
//  Holds them stable on the datapath for a per-opcode multicycle budget. Then captures the datapath
//  result and returns it to the CPU with a one-cycle complete pulse.
// PARAMETERS
//  LAT_ADD   2   cycles datapath inputs held stable for opcode 0/1 (add/sub); legal range 1..15
//  LAT_MUL   3   cycles for opcode 2 (mult); legal range 1..15
//  LAT_DIV   8   cycles for opcode 3 (div); legal range 1..15
// PORTS
//  clk_i           in   1   clock; all state updates on rising edge
//  rst_n_i         in   1   reset, synchronous, active-low
//  user_valid_i    in   1   UDI request strobe
//  user_opcode_i   in   11  UDI opcode
//  user_op0_i      in   32  UDI operand 0 (IEEE-754 single)
//  user_op1_i      in   32  UDI operand 1 (IEEE-754 single)
//  user_result_o   out  32  result, valid when user_complete_o=1
//  user_complete_o out  1   one-cycle completion pulse
//  illegal_o       out  1   pulses with user_complete_o when opcode > 3
//  busy_o          out  1   1 in EXEC or DONE
//  dp_opcode_o     out  11  to datapath opcode
//  dp_op0_o        out  32  to datapath op0
//  dp_op1_o        out  32  to datapath op1
//  dp_result_i     in   32  from datapath result
//  op_count_o      out  32  count of completed requests (legal + illegal), wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (rst_n_i=0 at edge): state=IDLE, all outputs 0, cnt=0, op_count_o=0. Applies in any state.
//   Mid-operation reset aborts: no complete pulse is produced for the aborted request.
//  FSM IDLE/EXEC/DONE:
//   IDLE: user_valid_i=1 at edge -> register opcode/op0/op1 onto dp_*_o.
//    Legal opcode (0..3): cnt <= LAT(opcode)-1, go EXEC.
//    Illegal opcode (>3): go DONE directly; result 0, illegal flag set.
//   EXEC: cnt!=0 -> cnt-1; cnt==0 -> user_result_o <= dp_result_i, go DONE.
//   DONE: user_complete_o=1 (and illegal_o if flagged) for exactly this cycle, op_count_o+1, go IDLE.
//  Registered outputs: user_complete_o, illegal_o and user_result_o are registers decoded from state.
//   No combinational path from user_*_i to any output.
//  Latency: valid sampled in cycle 0 -> complete high in cycle LAT+1 (legal), cycle 1 (illegal).
//  dp_*_o held constant from acceptance until the next acceptance (not cleared in IDLE).
//  user_result_o holds its value until the next capture; it is 0 after an illegal op.
//  user_valid_i is ignored while busy_o=1: no queueing, no error.
//   Next acceptance is possible in the cycle after DONE.
//  Opcodes 0..3 are passed through unchanged; no sign manipulation in this block.
// TESTING
//  add: valid, opc=0, op0=0x3F800000, op1=0x40000000, LAT_ADD=2
//   -> complete in cycle 3, result=0x40400000, op_count=1
//  div: opc=3, op0=0x41200000, op1=0x40000000
//   -> dp_* stable for 8 cycles; complete in cycle 9; result=0x40A00000
//  illegal: opc=11'd7 -> complete+illegal in cycle 1, result 0, dp_* not driven to datapath use
//  valid held high throughout EXEC/DONE -> exactly one complete per acceptance
//   -> back-to-back mul ops complete in cycles 4 and 9
//  reset mid-op: rst_n_i=0 in EXEC cycle 2 of div -> no complete ever, all outputs 0
//   -> new add after reset completes normally
//  wrap: preload op_count via 2^32-1 forced value -> one more op -> op_count_o=0

Source files
------------

// File: rtl/float_copro_ctrl.sv
// Sequencer between the LM32 UDI port and the combinational float datapath.
// Holds operands stable for a per-opcode budget, then returns the captured result.
module float_copro_ctrl #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        user_valid_i,
  input  logic [10:0] user_opcode_i,
  input  logic [31:0] user_op0_i,
  input  logic [31:0] user_op1_i,
  output logic [31:0] user_result_o,
  output logic        user_complete_o,
  output logic        illegal_o,
  output logic        busy_o,
  output logic [10:0] dp_opcode_o,
  output logic [31:0] dp_op0_o,
  output logic [31:0] dp_op1_o,
  input  logic [31:0] dp_result_i,
  output logic [31:0] op_count_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] count_q;
  logic        legal;
  logic [3:0]  lat_m1;

  assign legal      = (user_opcode_i[10:2] == 9'd0);
  assign busy_o     = (state == S_EXEC) || (state == S_DONE);
  assign op_count_o = count_q;

  always_comb begin
    lat_m1 = 4'd0;
    unique case (1'b1)
      (user_opcode_i[1:0] == 2'd2): lat_m1 = 4'(LAT_MUL - 1);
      (user_opcode_i[1:0] == 2'd3): lat_m1 = 4'(LAT_DIV - 1);
      default:                      lat_m1 = 4'(LAT_ADD - 1);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state           <= S_IDLE;
      cnt             <= 4'd0;
      count_q         <= 32'd0;
      user_result_o   <= 32'd0;
      user_complete_o <= 1'b0;
      illegal_o       <= 1'b0;
      dp_opcode_o     <= 11'd0;
      dp_op0_o        <= 32'd0;
      dp_op1_o        <= 32'd0;
    end else begin
      user_complete_o <= 1'b0;
      illegal_o       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (user_valid_i) begin
            dp_opcode_o <= user_opcode_i;
            dp_op0_o    <= user_op0_i;
            dp_op1_o    <= user_op1_i;
            if (legal) begin
              cnt   <= lat_m1;
              state <= S_EXEC;
            end else begin
              // Illegal opcodes skip the datapath and report a zero result.
              user_result_o   <= 32'd0;
              user_complete_o <= 1'b1;
              illegal_o       <= 1'b1;
              state           <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            user_result_o   <= dp_result_i;
            user_complete_o <= 1'b1;
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          count_q <= count_q + 32'd1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_copro_ctrl.sv
// Scoreboard bench for float_copro_ctrl with a stand-in datapath.
// Driver predicts completions from latency rules; a monitor checks them.
module tb_float_copro_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [10:0] opcode = '0;
  logic [31:0] op0 = '0;
  logic [31:0] op1 = '0;
  logic [31:0] result;
  logic        complete;
  logic        illegal;
  logic        busy;
  logic [10:0] dp_opcode;
  logic [31:0] dp_op0;
  logic [31:0] dp_op1;
  logic [31:0] dp_result;
  logic [31:0] op_count;

  float_copro_ctrl #(.LAT_ADD(2), .LAT_MUL(3), .LAT_DIV(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .user_valid_i(valid), .user_opcode_i(opcode),
    .user_op0_i(op0), .user_op1_i(op1),
    .user_result_o(result), .user_complete_o(complete),
    .illegal_o(illegal), .busy_o(busy),
    .dp_opcode_o(dp_opcode), .dp_op0_o(dp_op0), .dp_op1_o(dp_op1),
    .dp_result_i(dp_result), .op_count_o(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dp_fn(logic [10:0] o, logic [31:0] a, logic [31:0] b);
    return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]} ^ {21'd0, o} ^ 32'h5A5A0000;
  endfunction

  assign dp_result = dp_fn(dp_opcode, dp_op0, dp_op1);

  function automatic int lat_of(logic [10:0] o);
    case (o)
      11'd0, 11'd1: return 2;
      11'd2:        return 3;
      11'd3:        return 8;
      default:      return 0;
    endcase
  endfunction

  typedef struct {
    int          done;
    logic [31:0] res;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          free_at = 0;
  int          win_lo = 1;
  int          win_hi = 0;
  logic [10:0] w_opc = '0;
  logic [31:0] w_a = '0;
  logic [31:0] w_b = '0;
  logic [31:0] exp_cnt = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  task automatic cycle_in(logic v, logic [10:0] o, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int   l;
    @(negedge clk);
    rst_n  = 1'b1;
    valid  = v;
    opcode = o;
    op0    = a;
    op1    = b;
    if (v && cyc >= free_at) begin
      l      = lat_of(o);
      e.done = cyc + l + 1;
      e.ill  = (o > 11'd3);
      e.res  = e.ill ? 32'd0 : dp_fn(o, a, b);
      q.push_back(e);
      free_at = e.done + 1;
      win_lo  = cyc + 1;
      win_hi  = e.done;
      w_opc   = o;
      w_a     = a;
      w_b     = b;
    end
  endtask

  task automatic do_reset();
    exp_t keep[$];
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    foreach (q[i]) if (q[i].done < cyc) keep.push_back(q[i]);
    q       = keep;
    free_at = 0;
    win_lo  = 1;
    win_hi  = 0;
    exp_cnt = '0;
    chk("rst_complete", 32'(complete), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dp_opcode", 32'(dp_opcode), 32'd0);
    chk("rst_dp_op0", dp_op0, 32'd0);
    chk("rst_dp_op1", dp_op1, 32'd0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle_in(1'b0, 11'd0, 32'd0, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    logic in_win;
    forever begin
      @(negedge clk);
      #1;
      in_win = (cyc >= win_lo) && (cyc <= win_hi);
      chk("busy", 32'(busy), 32'(in_win));
      if (in_win) begin
        chk("dp_opcode_held", 32'(dp_opcode), 32'(w_opc));
        chk("dp_op0_held", dp_op0, w_a);
        chk("dp_op1_held", dp_op1, w_b);
      end
      chk("op_count", op_count, exp_cnt);
      if (complete) begin
        if (q.size() == 0) begin
          chk("spurious_complete", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("complete_cycle", 32'(cyc), 32'(e.done));
          chk("result", result, e.res);
          chk("illegal", 32'(illegal), 32'(e.ill));
          exp_cnt = exp_cnt + 32'd1;
        end
      end else begin
        chk("illegal_without_complete", 32'(illegal), 32'd0);
        if (q.size() != 0 && q[0].done <= cyc) begin
          e = q.pop_front();
          chk("missing_complete", 32'(cyc), 32'(e.done));
        end
      end
    end
  end

  initial begin : driver
    logic [10:0] o;
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", op_count, 32'd0);
    // add 1.0 + 2.0
    cycle_in(1'b1, 11'd0, 32'h3F800000, 32'h40000000);
    idle(5);
    // div 10.0 / 2.0
    cycle_in(1'b1, 11'd3, 32'h41200000, 32'h40000000);
    idle(11);
    cycle_in(1'b1, 11'd7, 32'h12345678, 32'h9ABCDEF0);
    idle(3);
    // valid held across two back-to-back mults
    for (int i = 0; i < 10; i++)
      cycle_in(1'b1, 11'd2, 32'h40400000 + i, 32'h40800000);
    idle(6);
    // reset in the second exec cycle of a div
    cycle_in(1'b1, 11'd3, 32'h41200000, 32'h40000000);
    idle(1);
    do_reset();
    idle(12);
    cycle_in(1'b1, 11'd1, 32'h40A00000, 32'h3F800000);
    idle(5);
    // counter wrap
    @(negedge clk);
    force dut.count_q = 32'hFFFFFFFF;
    exp_cnt = 32'hFFFFFFFF;
    idle(1);
    release dut.count_q;
    idle(1);
    cycle_in(1'b1, 11'd0, 32'h3F800000, 32'h3F800000);
    idle(5);
    chk("wrap_count", op_count, 32'd0);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        o = ($urandom_range(0, 9) < 8) ? 11'($urandom_range(0, 3))
                                       : 11'($urandom_range(4, 2047));
        cycle_in($urandom_range(0, 2) != 0, o, $urandom, $urandom);
      end
    end
    idle(15);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
